// File: rtl/fin_data_demux.sv
// Serial-to-parallel demux: collects 11 signed words from a valid/ready stream
// into per-channel registers Dout0..Dout10, then pulses done for one cycle.
module fin_data_demux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 11
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         start,
    input  logic                         din_valid,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic                         din_ready,
    output logic [3:0]                   select,
    output logic signed [DATA_WIDTH-1:0] Dout0,
    output logic signed [DATA_WIDTH-1:0] Dout1,
    output logic signed [DATA_WIDTH-1:0] Dout2,
    output logic signed [DATA_WIDTH-1:0] Dout3,
    output logic signed [DATA_WIDTH-1:0] Dout4,
    output logic signed [DATA_WIDTH-1:0] Dout5,
    output logic signed [DATA_WIDTH-1:0] Dout6,
    output logic signed [DATA_WIDTH-1:0] Dout7,
    output logic signed [DATA_WIDTH-1:0] Dout8,
    output logic signed [DATA_WIDTH-1:0] Dout9,
    output logic signed [DATA_WIDTH-1:0] Dout10,
    output logic                         busy,
    output logic                         done
);

    localparam logic [3:0] LAST_SEL = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              select_q, select_d;
    logic [DATA_WIDTH-1:0]   dout_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   dout_d [NUM_CH];
    logic                    transfer;

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        transfer = 1'b0;
        case (state_q)
            ST_IDLE: begin
                select_d = '0;
                if (start) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (din_valid) begin
                    transfer = 1'b1;
                    if (select_q == LAST_SEL) begin
                        select_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        select_d = select_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                select_d = '0;
            end
        endcase
    end

    // Only the channel addressed by select captures din on a transfer.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign dout_d[gi] = (transfer && (select_q == 4'(gi))) ? din : dout_q[gi];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            select_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            for (int i = 0; i < NUM_CH; i++) begin
                dout_q[i] <= dout_d[i];
            end
        end
    end

    // Handshake and status are pure state decodes, so no input reaches an output combinationally.
    assign din_ready = (state_q == ST_COLLECT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign select    = select_q;

    assign Dout0  = dout_q[0];
    assign Dout1  = dout_q[1];
    assign Dout2  = dout_q[2];
    assign Dout3  = dout_q[3];
    assign Dout4  = dout_q[4];
    assign Dout5  = dout_q[5];
    assign Dout6  = dout_q[6];
    assign Dout7  = dout_q[7];
    assign Dout8  = dout_q[8];
    assign Dout9  = dout_q[9];
    assign Dout10 = dout_q[10];

endmodule

// File: tb/tb_fin_data_demux.sv
// Scoreboard bench for fin_data_demux: a frame-level model predicts per-cycle status
// and completed frames; a monitor compares them against the DUT on the falling edge.
module tb_fin_data_demux;

    localparam int DW  = 8;
    localparam int NCH = 11;
    localparam int FW  = DW * NCH;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic                 Reset_n;
    logic                 start;
    logic                 din_valid;
    logic signed [DW-1:0] din;
    logic                 din_ready;
    logic [3:0]           select;
    logic signed [DW-1:0] dout_w [NCH];
    logic                 busy;
    logic                 done;
    logic [FW-1:0]        dout_flat;

    fin_data_demux #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .din_valid(din_valid), .din(din),
        .din_ready(din_ready), .select(select),
        .Dout0(dout_w[0]), .Dout1(dout_w[1]), .Dout2(dout_w[2]), .Dout3(dout_w[3]),
        .Dout4(dout_w[4]), .Dout5(dout_w[5]), .Dout6(dout_w[6]), .Dout7(dout_w[7]),
        .Dout8(dout_w[8]), .Dout9(dout_w[9]), .Dout10(dout_w[10]),
        .busy(busy), .done(done)
    );

    always_comb begin
        dout_flat = '0;
        for (int i = 0; i < NCH; i++) dout_flat[i*DW +: DW] = dout_w[i];
    end

    int cycle_cnt = 0;
    always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int            cyc;
        logic          busy;
        logic          ready;
        logic          done;
        logic [3:0]    sel;
        logic [FW-1:0] dout;
    } status_t;

    typedef struct packed {
        int            cyc;
        logic [FW-1:0] dout;
    } frame_t;

    status_t status_q[$];
    frame_t  frame_q[$];

    // Frame-level reference: words collected so far in the current frame plus the channel memory.
    typedef enum {M_IDLE, M_COLL, M_DONE} mode_t;
    mode_t         m_mode = M_IDLE;
    logic [DW-1:0] m_mem [NCH];
    logic [DW-1:0] m_words[$];

    function automatic logic [FW-1:0] pack_mem();
        logic [FW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*DW +: DW] = m_mem[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle_cnt, act, exp);
        end
    endtask

    task automatic model_step();
        status_t s;
        frame_t  f;
        if (!Reset_n) begin
            for (int i = 0; i < NCH; i++) m_mem[i] = '0;
            m_words.delete();
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start) m_mode = M_COLL;
                M_COLL: begin
                    if (din_valid) begin
                        m_mem[m_words.size()] = din;
                        m_words.push_back(din);
                        if (m_words.size() == NCH) begin
                            m_words.delete();
                            m_mode = M_DONE;
                            f.cyc  = cycle_cnt + 1;
                            f.dout = pack_mem();
                            frame_q.push_back(f);
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        s.cyc   = cycle_cnt + 1;
        s.busy  = (m_mode != M_IDLE);
        s.ready = (m_mode == M_COLL);
        s.done  = (m_mode == M_DONE);
        s.sel   = (m_mode == M_COLL) ? 4'(m_words.size()) : 4'd0;
        s.dout  = pack_mem();
        status_q.push_back(s);
    endtask

    always @(negedge Clk) begin
        status_t s;
        frame_t  f;
        if (status_q.size() > 0 && status_q[0].cyc == cycle_cnt) begin
            s = status_q.pop_front();
            chk("busy", 128'(busy), 128'(s.busy));
            chk("din_ready", 128'(din_ready), 128'(s.ready));
            chk("done", 128'(done), 128'(s.done));
            chk("select", 128'(select), 128'(s.sel));
            chk("dout_all", 128'(dout_flat), 128'(s.dout));
        end
        if (done === 1'b1) begin
            if (frame_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected at cycle %0d: got done=1, expected no frame", cycle_cnt);
            end else begin
                f = frame_q.pop_front();
                chk("done_cycle", 128'(cycle_cnt), 128'(f.cyc));
                chk("frame_dout", 128'(dout_flat), 128'(f.dout));
                $display("frame done at cycle %0d: Dout0=%0d Dout1=%0d Dout2=%0d Dout10=%0d",
                         cycle_cnt, dout_w[0], dout_w[1], dout_w[2], dout_w[10]);
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
        Reset_n   = r;
        start     = s;
        din_valid = v;
        din       = d;
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [DW-1:0] sv [NCH];
        sv = '{8'h80, 8'h7F, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'hFE, 8'h40, 8'hC0, 8'h33, 8'hCC};
        Reset_n = 1'b0; start = 1'b0; din_valid = 1'b0; din = '0;
        @(posedge Clk);
        #1;

        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) step(1'b1, 1'b0, 1'b1, 8'h3C);

        // basic frame, din = 0..10
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < NCH; k++) step(1'b1, 1'b0, 1'b1, 8'(k));
        idle(3);

        // stall on every other cycle
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < NCH; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'($urandom));
            step(1'b1, 1'b0, 1'b1, 8'(k));
        end
        idle(3);

        // signed extremes
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < NCH; k++) step(1'b1, 1'b0, 1'b1, sv[k]);
        idle(2);

        // start pulses during COLLECT, valid during DONE/IDLE
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < NCH; k++) step(1'b1, 1'(k % 2), 1'b1, 8'(k + 100));
        repeat (3) step(1'b1, 1'b0, 1'b1, 8'h3C);

        // mid-frame reset after 5 transfers, then a normal frame
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 8'(k + 50));
        step(1'b0, 1'b1, 1'b1, 8'h77);
        idle(2);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < NCH; k++) step(1'b1, 1'b0, 1'b1, 8'($urandom));
        idle(3);

        // back-to-back frames with start held high
        repeat (30) step(1'b1, 1'b1, 1'b1, 8'($urandom));
        idle(3);

        // random traffic with occasional resets
        repeat (400) step(($urandom_range(59) != 0), ($urandom_range(2) == 0),
                          ($urandom_range(2) != 0), 8'($urandom));
        idle(16);

        @(negedge Clk);
        #1;
        chk("status_drained", 128'(status_q.size()), 128'(0));
        chk("frames_drained", 128'(frame_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fin_data_demux.md
FIN_DATA_DEMUX -- requirements
Module: fin_data_demux

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the signed word width of din and Dout0..Dout10.
REQ-002 The block SHALL have parameter NUM_CH, fixed at 11, the number of output channels; values other than 11 are unsupported.
REQ-003 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  reset, synchronous, active-low; sampled only on the rising edge of Clk.
REQ-005 start  input  1  request to begin one 11-word collection frame.
REQ-006 din_valid  input  1  din carries a valid word this cycle.
REQ-007 din  input  DATA_WIDTH (signed)  serial data word for channel select.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 select  output  4  index (0..10) of the channel the next accepted word is written to; drives the upstream 11:1 address mux select.
REQ-010 Dout0..Dout10  output  DATA_WIDTH (signed) each  registered per-channel data.
REQ-011 busy  output  1  high while a frame is in progress (COLLECT or DONE).
REQ-012 done  output  1  single-cycle pulse marking frame completion.

Function
REQ-013 The block SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-014 IDLE: din_ready=0, busy=0, done=0, select=0; start=1 SHALL move to COLLECT next cycle.
REQ-015 COLLECT: din_ready=1, busy=1; a word SHALL be accepted only on a cycle with din_valid=1 and din_ready=1 (transfer).
REQ-016 On a transfer, Dout[select] SHALL load din at that clock edge; no other Dout changes.
REQ-017 On a transfer with select<10, select SHALL increment by 1; with select==10, select SHALL return to 0 and the FSM SHALL move to DONE.
REQ-018 Cycles in COLLECT with din_valid=0 SHALL hold select and all Dout unchanged (stall, unbounded).
REQ-019 DONE: done=1, busy=1, din_ready=0 for exactly one cycle, then unconditionally IDLE.
REQ-020 start SHALL be ignored in COLLECT and DONE; start held high in IDLE after DONE SHALL begin a new frame (at most one cycle gap: DONE -> IDLE -> COLLECT).
REQ-021 din_valid in IDLE or DONE SHALL be ignored; no Dout changes.
REQ-022 Dout0..Dout10 SHALL hold their last values across frames until overwritten; a new frame does not clear them.
REQ-023 Latency: minimum frame is 11 consecutive transfers; done asserts the cycle after the 11th transfer edge, i.e. start-to-done is 13 cycles with din_valid held high.
REQ-024 select SHALL never take a value above 10.
REQ-025 din is stored bit-exact; no arithmetic, sign extension, or truncation.
REQ-026 All outputs SHALL be driven from registers or decoded solely from FSM state (no combinational path from din/din_valid/start to any output).

Reset
REQ-027 With Reset_n=0 at a rising edge of Clk, the FSM SHALL enter IDLE, select=0, Dout0..Dout10=0, done=0, busy=0, din_ready=0, taking priority over all other inputs.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without a done pulse; partially written Dout values SHALL be cleared to 0.
REQ-029 Outputs between power-up and the first reset edge are undefined; the bench SHALL apply reset for at least 2 cycles.

Verification
REQ-030 Basic frame: reset, start=1 one cycle, din_valid=1 with din=0..10 on consecutive cycles -> DoutK=K, select steps 0..10, done pulse exactly 1 cycle at cycle 13 after start, busy low afterwards.
REQ-031 Stalls: same frame with din_valid=0 on every other cycle -> identical final Dout values, select holds during stalls, done at cycle 24.
REQ-032 Signed data (DATA_WIDTH=8): din=-128, 127, -1, 0x55... -> Dout0=-128 (0x80), Dout1=127, Dout2=-1 (0xFF), exact bit patterns preserved.
REQ-033 Ignored inputs: din_valid=1 with din=0x3C in IDLE, and start pulses during COLLECT -> no Dout change in IDLE, frame length still 11 transfers, single done pulse.
REQ-034 Mid-frame reset: after 5 transfers, Reset_n=0 one cycle -> all Dout=0, select=0, IDLE, no done pulse; subsequent full frame completes normally.
REQ-035 Back-to-back: start held high continuously, din_valid=1 -> two frames complete, second frame's Dout overwrite the first, done pulses 13 cycles apart.
